// File: rtl/rfi_flagger.sv
// rfi_flagger: per-channel RFI flagger with correlation/power ratio test and per-channel hold counters.
// Optional statistics are enabled by defining RFI_FLAGGER_STATS_EN.
// Ports: clk, rst (sync, active-high); pow_data/corr_data/din_valid/sync_in carry one channel per valid;
// threshold (UFix THRESH_WIDTH.THRESH_POINT) and hold_len are sampled with each sample;
// dout_flag/dout_channel/dout_valid/frame_end appear 3 cycles after din_valid; busy is high during the RAM clear;
// flag_count/count_valid report flagged channels per completed frame (zero unless stats are enabled).
module rfi_flagger #(
  parameter int DIN_WIDTH    = 18,
  parameter int CHANNEL_ADDR = 9,
  parameter int THRESH_WIDTH = 16,
  parameter int THRESH_POINT = 12,
  parameter int HOLD_WIDTH   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DIN_WIDTH-1:0]    pow_data,
  input  logic [DIN_WIDTH-1:0]    corr_data,
  input  logic                    din_valid,
  input  logic                    sync_in,
  input  logic [THRESH_WIDTH-1:0] threshold,
  input  logic [HOLD_WIDTH-1:0]   hold_len,
  output logic                    dout_flag,
  output logic [CHANNEL_ADDR-1:0] dout_channel,
  output logic                    dout_valid,
  output logic                    frame_end,
  output logic                    busy,
  output logic [CHANNEL_ADDR:0]   flag_count,
  output logic                    count_valid
);
  localparam int PW = DIN_WIDTH + THRESH_WIDTH;
  localparam logic [CHANNEL_ADDR-1:0] LAST = '1;
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state_q;
  logic [HOLD_WIDTH-1:0] ram [2**CHANNEL_ADDR];
  logic [CHANNEL_ADDR-1:0] clr_addr_q, ch_q, s1_ch_q, s2_ch_q, in_ch, waddr;
  logic [HOLD_WIDTH-1:0] s1_hold_q, rd_q, cnt_d, wdata;
  logic s1_valid_q, s1_exc_q, s2_valid_q, s2_flag_q, accept, exc, flag_d, we;
  logic [PW-1:0] lhs, rhs;
  assign busy = state_q == CLEAR;
  assign accept = state_q == RUN && din_valid;
  // sync_in makes the coincident sample channel 0
  assign in_ch = sync_in ? '0 : ch_q;
  // full-width comparison so neither side can truncate
  assign lhs = PW'(corr_data) << THRESH_POINT;
  assign rhs = PW'(pow_data) * PW'(threshold);
  assign exc = lhs > rhs;
  always_comb begin
    cnt_d = s1_exc_q ? s1_hold_q : (rd_q != '0 ? rd_q - HOLD_WIDTH'(1) : '0);
    flag_d = s1_exc_q | (rd_q != '0);
    we = state_q == CLEAR || s1_valid_q;
    waddr = state_q == CLEAR ? clr_addr_q : s1_ch_q;
    wdata = state_q == CLEAR ? '0 : cnt_d;
  end
  // a channel recurs no sooner than 4 samples later, so the read never needs the pending write
  always_ff @(posedge clk) begin
    if (we) ram[waddr] <= wdata;
    rd_q <= ram[in_ch];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      clr_addr_q <= '0;
      ch_q <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      dout_valid <= 1'b0;
      dout_flag <= 1'b0;
      dout_channel <= '0;
      frame_end <= 1'b0;
    end else begin
      if (state_q == CLEAR) begin
        clr_addr_q <= clr_addr_q + CHANNEL_ADDR'(1);
        if (clr_addr_q == LAST) state_q <= RUN;
      end else begin
        ch_q <= in_ch + CHANNEL_ADDR'(din_valid);
      end
      s1_valid_q <= accept;
      s2_valid_q <= s1_valid_q;
      dout_valid <= s2_valid_q;
      dout_flag <= s2_valid_q & s2_flag_q;
      dout_channel <= s2_ch_q;
      frame_end <= s2_valid_q && s2_ch_q == LAST;
    end
  end
  always_ff @(posedge clk) begin
    s1_ch_q <= in_ch;
    s1_exc_q <= exc;
    s1_hold_q <= hold_len;
    s2_ch_q <= s1_ch_q;
    s2_flag_q <= flag_d;
  end
`ifdef RFI_FLAGGER_STATS_EN
  logic s1_sync_q, s2_sync_q, cv_q;
  logic [CHANNEL_ADDR:0] run_q, fc_q, tot;
  // the sync marker travels with the pipeline so earlier in-flight samples land in the dropped count
  assign tot = (s2_sync_q ? '0 : run_q) + (CHANNEL_ADDR+1)'(s2_valid_q & s2_flag_q);
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_sync_q <= 1'b0;
      s2_sync_q <= 1'b0;
      cv_q <= 1'b0;
      run_q <= '0;
      fc_q <= '0;
    end else begin
      s1_sync_q <= state_q == RUN && sync_in;
      s2_sync_q <= s1_sync_q;
      cv_q <= s2_valid_q && s2_ch_q == LAST;
      run_q <= (s2_valid_q && s2_ch_q == LAST) ? '0 : tot;
      if (s2_valid_q && s2_ch_q == LAST) fc_q <= tot;
    end
  end
  assign flag_count = fc_q;
  assign count_valid = cv_q;
`else
  assign flag_count = '0;
  assign count_valid = 1'b0;
`endif
endmodule

// File: tb/tb_rfi_flagger.sv
// tb_rfi_flagger: randomized scoreboard bench for rfi_flagger against a behavioural channel/hold model.
module tb_rfi_flagger;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [17:0] pow_data = '0, corr_data = '0;
  logic din_valid = 1'b0, sync_in = 1'b0;
  logic [15:0] threshold = 16'd4096;
  logic [7:0] hold_len = '0;
  logic dout_flag, dout_valid, frame_end, busy, count_valid;
  logic [8:0] dout_channel;
  logic [9:0] flag_count;
  rfi_flagger dut (
    .clk(clk), .rst(rst), .pow_data(pow_data), .corr_data(corr_data), .din_valid(din_valid),
    .sync_in(sync_in), .threshold(threshold), .hold_len(hold_len), .dout_flag(dout_flag),
    .dout_channel(dout_channel), .dout_valid(dout_valid), .frame_end(frame_end), .busy(busy),
    .flag_count(flag_count), .count_valid(count_valid)
  );
  always #5 clk = ~clk;
  typedef struct {bit flag; int ch; bit fe; int cnt; longint iss;} exp_t;
  exp_t q[$];
  longint cyc = 0;
  int n_chk = 0, n_fail = 0;
  int m_hold[512];
  int m_ch = 0, m_run = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, longint act, longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (dout_valid === 1'b1) begin
      if (q.size() == 0) chk("spurious_dout_valid", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("dout_flag", dout_flag, e.flag);
        chk("dout_channel", dout_channel, e.ch);
        chk("frame_end", frame_end, e.fe);
        chk("latency", cyc - e.iss, 3);
`ifdef RFI_FLAGGER_STATS_EN
        chk("count_valid", count_valid, e.fe);
        if (e.fe) chk("flag_count", flag_count, e.cnt);
`else
        chk("stats_tied_zero", {flag_count, count_valid}, 0);
`endif
      end
    end else if (count_valid === 1'b1) chk("count_valid_without_dout", 1, 0);
  end
  task automatic sample(bit v, bit s, int pw, int cr, int th, int hl);
    exp_t e;
    bit exc;
    @(posedge clk); #1;
    din_valid = v; sync_in = s; pow_data = 18'(pw); corr_data = 18'(cr);
    threshold = 16'(th); hold_len = 8'(hl);
    if (s) begin m_ch = 0; m_run = 0; end
    if (v) begin
      exc = (longint'(cr) * 4096) > (longint'(pw) * th);
      e.flag = exc || m_hold[m_ch] > 0;
      m_hold[m_ch] = exc ? hl : (m_hold[m_ch] > 0 ? m_hold[m_ch] - 1 : 0);
      m_run += int'(e.flag);
      e.ch = m_ch; e.fe = m_ch == 511; e.cnt = m_run; e.iss = cyc;
      if (e.fe) m_run = 0;
      q.push_back(e);
      m_ch = (m_ch + 1) % 512;
    end
  endtask
  task automatic idle(int n);
    repeat (n) sample(0, 0, 0, 0, 4096, 0);
  endtask
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; din_valid = 1'b0; sync_in = 1'b0;
    while (q.size() > 0 && q[$].iss >= cyc - 2) void'(q.pop_back());
    m_ch = 0; m_run = 0;
    foreach (m_hold[i]) m_hold[i] = 0;
    @(posedge clk); #1;
    chk("rst_busy", busy, 1);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_dout_flag", dout_flag, 0);
    chk("rst_dout_channel", dout_channel, 0);
    chk("rst_frame_end", frame_end, 0);
    chk("rst_stats", {flag_count, count_valid}, 0);
    rst = 1'b0;
  endtask
  task automatic wait_busy();
    int n = 0;
    forever begin
      @(negedge clk);
      if (!busy || n >= 2000) break;
      n++;
    end
    chk("busy_cycles", n, 512);
  endtask
  function automatic int rp();
    return int'($urandom_range(1, 200000));
  endfunction
  initial begin
    int pw, ex;
    do_reset();
    wait_busy();
    for (int f = 0; f < 2; f++)
      for (int c = 0; c < 512; c++) begin
        pw = (c == 5) ? 100 : rp();
        sample(1, c == 0, pw, (c == 5) ? (f == 0 ? 101 : 100) : int'($urandom_range(0, pw)), 4096, 0);
      end
    for (int f = 0; f < 5; f++)
      for (int c = 0; c < 512; c++) begin
        ex = int'(f == 0 && (c == 7 || (c >= 20 && c < 29)));
        pw = rp();
        sample(1, 0, pw, ex != 0 ? pw + 1 : int'($urandom_range(0, pw)), 4096, 3);
      end
    for (int i = 0; i < 700; i++)
      sample($urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0, int'($urandom_range(0, 262143)),
             int'($urandom_range(0, 262143)), int'($urandom_range(0, 65535)), int'($urandom_range(0, 7)));
    sample(1, 1, rp(), 0, 4096, 0);
    for (int c = 1; c < 200; c++) sample(1, 0, rp(), int'($urandom_range(0, 262143)), 4096, 2);
    sample(1, 1, rp(), 0, 4096, 2);
    for (int i = 0; i < 530; i++) sample(1, 0, rp(), int'($urandom_range(0, 262143)), 4096, 2);
    sample(0, 1, 0, 0, 4096, 0);
    for (int c = 0; c < 300; c++) begin
      pw = rp();
      sample(1, 0, pw, $urandom_range(0, 1) != 0 ? pw + 1 : 0, 4096, 5);
    end
    do_reset();
    wait_busy();
    for (int c = 0; c < 530; c++) begin
      pw = rp();
      sample(1, 0, pw, int'($urandom_range(0, pw)), 4096, 0);
    end
    idle(1);
    repeat (100) @(posedge clk);
    do_reset();
    wait_busy();
    for (int c = 0; c < 520; c++) begin
      pw = rp();
      sample($urandom_range(0, 4) != 0, 0, pw, $urandom_range(0, 9) == 0 ? pw + 1 : 0, 4096, 1);
    end
    idle(8);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
